// File: rtl/rgbw_pkg.sv
// Shared encodings and constants for the RGBW update scheduler slice.
package rgbw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FADING  = 2'd2
  } state_t;

  localparam int MODE_FADE_BIT = 0;
  localparam int FRAME_BYTES   = 8;
  localparam int BYTE_CNT_W    = $clog2(FRAME_BYTES);

  // Level channel ordering inside the scheduler's level arrays.
  localparam int CH_LINT  = 0;
  localparam int CH_RED   = 1;
  localparam int CH_GREEN = 2;
  localparam int CH_BLUE  = 3;
  localparam int CH_WHITE = 4;
  localparam int N_LEVELS = 5;

endpackage

// File: rtl/rgbw_ramp_step.sv
// One fade step for a single 8-bit level: move one count toward the target.
module rgbw_ramp_step (
  input  logic [7:0] i_cur,
  input  logic [7:0] i_tgt,
  output logic [7:0] o_nxt,
  output logic       o_eq
);

  // Stepping only while strictly below/above the target keeps 0x00/0xFF safe.
  always_comb begin
    o_eq  = (i_cur == i_tgt);
    o_nxt = i_cur;
    if (i_cur < i_tgt) begin
      o_nxt = i_cur + 8'd1;
    end else if (i_cur > i_tgt) begin
      o_nxt = i_cur - 8'd1;
    end
  end

endmodule

// File: rtl/rgbw_update_scheduler.sv
// Latches RGBW frames as targets, releases them on PWM period boundaries
// (jump or +/-1 fade), and watches SPI byte strobes for stalled frames.
module rgbw_update_scheduler
  import rgbw_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_half,
  input  logic       rdy,
  input  logic       frame_stb,
  input  logic       period_end,
  input  logic [7:0] lint_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] white_in,
  input  logic [7:0] colorIdx_in,
  input  logic [7:0] mode_in,
  output logic [7:0] lint_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic [7:0] white_out,
  output logic [7:0] colorIdx_out,
  output logic [7:0] mode_out,
  output logic       applied,
  output logic       busy,
  output logic       link_timeout,
  output logic       resync,
  output logic [1:0] dbg_state
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t r_state;
  logic [7:0] r_lvl_tgt [N_LEVELS];
  logic [7:0] r_lvl_out [N_LEVELS];
  logic [7:0] r_cidx_tgt;
  logic [7:0] r_mode_tgt;
  logic [7:0] r_cidx_out;
  logic [7:0] r_mode_out;
  logic       r_applied;

  logic                  r_rdy_q1;
  logic                  r_rdy_q2;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [TO_W-1:0]       r_wd;
  logic                  r_link_timeout;
  logic                  r_resync;

  logic [7:0] w_lvl_in  [N_LEVELS];
  logic [7:0] w_lvl_nxt [N_LEVELS];
  logic       w_lvl_eq  [N_LEVELS];
  logic       w_step_done;
  logic       w_en;
  logic       w_rise;
  logic       w_wd_fire;

  assign w_en = ~clk_half;

  assign w_lvl_in[CH_LINT]  = lint_in;
  assign w_lvl_in[CH_RED]   = red_in;
  assign w_lvl_in[CH_GREEN] = green_in;
  assign w_lvl_in[CH_BLUE]  = blue_in;
  assign w_lvl_in[CH_WHITE] = white_in;

  for (genvar g = 0; g < N_LEVELS; g++) begin : g_ramp
    rgbw_ramp_step u_step (
      .i_cur (r_lvl_out[g]),
      .i_tgt (r_lvl_tgt[g]),
      .o_nxt (w_lvl_nxt[g]),
      .o_eq  (w_lvl_eq[g])
    );
  end

  // True when this step lands every channel on its target.
  always_comb begin
    w_step_done = 1'b1;
    for (int i = 0; i < N_LEVELS; i++) begin
      if (w_lvl_nxt[i] != r_lvl_tgt[i]) begin
        w_step_done = 1'b0;
      end
    end
  end

  // Period_end acts on the old target/state first; a same-cycle frame_stb
  // then overrides the target and forces PENDING.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cidx_tgt <= 8'd0;
      r_mode_tgt <= 8'd0;
      r_cidx_out <= 8'd0;
      r_mode_out <= 8'd0;
      r_applied  <= 1'b0;
      for (int i = 0; i < N_LEVELS; i++) begin
        r_lvl_tgt[i] <= 8'd0;
        r_lvl_out[i] <= 8'd0;
      end
    end else if (w_en) begin
      r_applied <= 1'b0;
      if (period_end && (r_state != ST_IDLE)) begin
        if (r_state == ST_PENDING) begin
          r_cidx_out <= r_cidx_tgt;
          r_mode_out <= r_mode_tgt;
        end
        if ((r_state == ST_PENDING) && !r_mode_tgt[MODE_FADE_BIT]) begin
          for (int i = 0; i < N_LEVELS; i++) begin
            r_lvl_out[i] <= r_lvl_tgt[i];
          end
          r_applied <= 1'b1;
          r_state   <= ST_IDLE;
        end else begin
          for (int i = 0; i < N_LEVELS; i++) begin
            r_lvl_out[i] <= w_lvl_nxt[i];
          end
          if (w_step_done) begin
            r_applied <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_FADING;
          end
        end
      end
      if (frame_stb) begin
        for (int i = 0; i < N_LEVELS; i++) begin
          r_lvl_tgt[i] <= w_lvl_in[i];
        end
        r_cidx_tgt <= colorIdx_in;
        r_mode_tgt <= mode_in;
        r_state    <= ST_PENDING;
      end
    end
  end

  assign w_rise    = r_rdy_q1 & ~r_rdy_q2;
  assign w_wd_fire = (r_byte_cnt != '0) && !w_rise && !frame_stb && (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdy_q1       <= 1'b0;
      r_rdy_q2       <= 1'b0;
      r_byte_cnt     <= '0;
      r_wd           <= '0;
      r_link_timeout <= 1'b0;
      r_resync       <= 1'b0;
    end else if (w_en) begin
      r_rdy_q1 <= rdy;
      r_rdy_q2 <= r_rdy_q1;
      r_resync <= w_wd_fire;

      if (frame_stb || w_wd_fire) begin
        r_byte_cnt <= '0;
      end else if (w_rise) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end

      if (frame_stb || w_rise || w_wd_fire) begin
        r_wd <= '0;
      end else if (r_byte_cnt != '0) begin
        r_wd <= r_wd + 1'b1;
      end

      if (frame_stb) begin
        r_link_timeout <= 1'b0;
      end else if (w_wd_fire) begin
        r_link_timeout <= 1'b1;
      end
    end
  end

  assign lint_out     = r_lvl_out[CH_LINT];
  assign red_out      = r_lvl_out[CH_RED];
  assign green_out    = r_lvl_out[CH_GREEN];
  assign blue_out     = r_lvl_out[CH_BLUE];
  assign white_out    = r_lvl_out[CH_WHITE];
  assign colorIdx_out = r_cidx_out;
  assign mode_out     = r_mode_out;
  assign applied      = r_applied;
  assign busy         = (r_state != ST_IDLE);
  assign link_timeout = r_link_timeout;
  assign resync       = r_resync;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_rgbw_update_scheduler.sv
// Directed bench for rgbw_update_scheduler: jump, fade, retarget and watchdog.
module tb_rgbw_update_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_half = 1'b0;
  logic       rdy = 1'b0;
  logic       frame_stb = 1'b0;
  logic       period_end = 1'b0;
  logic [7:0] lint_in = 8'd0, red_in = 8'd0, green_in = 8'd0, blue_in = 8'd0;
  logic [7:0] white_in = 8'd0, colorIdx_in = 8'd0, mode_in = 8'd0;
  logic [7:0] lint_out, red_out, green_out, blue_out, white_out, colorIdx_out, mode_out;
  logic       applied, busy, link_timeout, resync;
  logic [1:0] dbg_state;

  int n_chk = 0;
  int n_err = 0;

  rgbw_update_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .clk_half     (clk_half),
    .rdy          (rdy),
    .frame_stb    (frame_stb),
    .period_end   (period_end),
    .lint_in      (lint_in),
    .red_in       (red_in),
    .green_in     (green_in),
    .blue_in      (blue_in),
    .white_in     (white_in),
    .colorIdx_in  (colorIdx_in),
    .mode_in      (mode_in),
    .lint_out     (lint_out),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .white_out    (white_out),
    .colorIdx_out (colorIdx_out),
    .mode_out     (mode_out),
    .applied      (applied),
    .busy         (busy),
    .link_timeout (link_timeout),
    .resync       (resync),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    frame_stb = 1'b0;
    period_end = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clk_half = ~clk_half;
      tick();
    end
    clk_half = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] l, r, g, b, w, c, m);
    lint_in = l; red_in = r; green_in = g; blue_in = b;
    white_in = w; colorIdx_in = c; mode_in = m;
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
  endtask

  task automatic send_period();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({lint_out, red_out, green_out, blue_out, white_out, colorIdx_out, mode_out} !== 56'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {lint_out, red_out, green_out, blue_out, white_out});
    end
    n_chk++;
    if ({busy, link_timeout, applied, resync, dbg_state} !== 6'd0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000000", {busy, link_timeout, applied, resync, dbg_state});
    end
  endtask

  task automatic test_jump();
    do_reset();
    send_frame(8'h11, 8'h80, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00);
    n_chk++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      n_err++; $display("FAIL jump_pending: got busy=%b state=%0d expected busy=1 state=1", busy, dbg_state);
    end
    repeat (20) tick();
    // Disabled cycle: a period_end with clk_half high must be ignored.
    clk_half = 1'b1;
    send_period();
    clk_half = 1'b0;
    n_chk++;
    if (red_out !== 8'h00 || applied !== 1'b0) begin
      n_err++; $display("FAIL jump_hold: got red=%h applied=%b expected red=00 applied=0", red_out, applied);
    end
    send_period();
    n_chk++;
    if ({lint_out, red_out, green_out, blue_out, white_out, colorIdx_out, mode_out} !== 56'h11_80_22_33_44_55_00) begin
      n_err++; $display("FAIL jump_outputs: got %h expected 11802233445500",
                        {lint_out, red_out, green_out, blue_out, white_out, colorIdx_out, mode_out});
    end
    n_chk++;
    if (applied !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL jump_applied: got applied=%b busy=%b expected 1 0", applied, busy);
    end
    tick();
    n_chk++;
    if (applied !== 1'b0) begin
      n_err++; $display("FAIL jump_applied_once: got %b expected 0", applied);
    end
    // Reset must act even with clk_half high.
    reset = 1'b0;
    clk_half = 1'b1;
    tick();
    n_chk++;
    if (red_out !== 8'h00 || lint_out !== 8'h00) begin
      n_err++; $display("FAIL reset_async_en: got red=%h expected 00", red_out);
    end
    reset = 1'b1;
    clk_half = 1'b0;
    tick();
  endtask

  task automatic test_fade();
    do_reset();
    send_frame(8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_period();
    send_frame(8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h07, 8'h01);
    for (int k = 1; k <= 3; k++) begin
      send_period();
      n_chk++;
      if (red_out !== 8'(8'h10 + k) || applied !== (k == 3) || busy !== (k != 3)) begin
        n_err++; $display("FAIL fade_up_%0d: got red=%h applied=%b busy=%b expected red=%h", k, red_out, applied, busy, 8'(8'h10 + k));
      end
    end
    n_chk++;
    if (mode_out !== 8'h01 || colorIdx_out !== 8'h07) begin
      n_err++; $display("FAIL fade_meta: got mode=%h cidx=%h expected 01 07", mode_out, colorIdx_out);
    end
    send_frame(8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_period();
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    for (int k = 1; k <= 2; k++) begin
      send_period();
      n_chk++;
      if (red_out !== 8'(8'h02 - k) || applied !== (k == 2)) begin
        n_err++; $display("FAIL fade_down_%0d: got red=%h applied=%b expected red=%h", k, red_out, applied, 8'(8'h02 - k));
      end
    end
    send_period();
    n_chk++;
    if (red_out !== 8'h00 || applied !== 1'b0) begin
      n_err++; $display("FAIL fade_no_wrap: got red=%h applied=%b expected 00 0", red_out, applied);
    end
    // A frame equal to the current outputs still pends and applies.
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    n_chk++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL same_pending: got busy=%b expected 1", busy);
    end
    send_period();
    n_chk++;
    if (applied !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL same_applied: got applied=%b busy=%b expected 1 0", applied, busy);
    end
  endtask

  task automatic test_retarget();
    do_reset();
    send_frame(8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_period();
    send_frame(8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    send_period();
    send_period();
    send_frame(8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    repeat (3) tick();
    n_chk++;
    if (red_out !== 8'h12 || dbg_state !== 2'd1) begin
      n_err++; $display("FAIL retarget_hold: got red=%h state=%0d expected 12 1", red_out, dbg_state);
    end
    for (int v = 8'h11; v >= 8'h05; v--) begin
      send_period();
      n_chk++;
      if (red_out !== 8'(v) || applied !== (v == 8'h05)) begin
        n_err++; $display("FAIL retarget_step: got red=%h applied=%b expected red=%h", red_out, applied, 8'(v));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_period();
    send_frame(8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    send_period();
    n_chk++;
    if (red_out !== 8'h11 || dbg_state !== 2'd2) begin
      n_err++; $display("FAIL b2b_fading: got red=%h state=%0d expected 11 2", red_out, dbg_state);
    end
    lint_in = 8'h00; red_in = 8'h08; green_in = 8'h00; blue_in = 8'h00;
    white_in = 8'h00; colorIdx_in = 8'h00; mode_in = 8'h01;
    frame_stb = 1'b1;
    period_end = 1'b1;
    tick();
    frame_stb = 1'b0;
    period_end = 1'b0;
    n_chk++;
    if (red_out !== 8'h12 || dbg_state !== 2'd1 || applied !== 1'b0) begin
      n_err++; $display("FAIL b2b_old_step: got red=%h state=%0d applied=%b expected 12 1 0", red_out, dbg_state, applied);
    end
    for (int v = 8'h11; v >= 8'h08; v--) begin
      send_period();
      n_chk++;
      if (red_out !== 8'(v) || applied !== (v == 8'h08)) begin
        n_err++; $display("FAIL b2b_new_step: got red=%h applied=%b expected red=%h", red_out, applied, 8'(v));
      end
    end
  endtask

  task automatic test_timeout();
    int first_hit;
    int hits;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      rdy = 1'b1; tick(); tick();
      rdy = 1'b0; tick(); tick();
    end
    first_hit = -1;
    hits = 0;
    for (int i = 1; i <= 4300; i++) begin
      tick();
      if (resync === 1'b1) begin
        hits++;
        if (first_hit < 0) first_hit = i;
      end
    end
    n_chk++;
    if (hits !== 1) begin
      n_err++; $display("FAIL timeout_pulses: got %0d expected 1", hits);
    end
    n_chk++;
    if (first_hit < 4085 || first_hit > 4105) begin
      n_err++; $display("FAIL timeout_time: got cycle %0d expected about 4094", first_hit);
    end
    n_chk++;
    if (link_timeout !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_flag: got link_timeout=%b busy=%b expected 1 0", link_timeout, busy);
    end
    send_frame(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    n_chk++;
    if (link_timeout !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL timeout_clear: got link_timeout=%b busy=%b expected 0 1", link_timeout, busy);
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_fade();
    test_retarget();
    test_back_to_back();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
